// File: rtl/fixed_to_bf16_pipe.sv
// Multi-lane two-stage pipeline that converts signed Q-format accumulator words to BF16.
// It supports truncate or round-to-nearest-even per beat and full valid/ready backpressure.
module fixed_to_bf16_pipe #(
    parameter int IN_W      = 18,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rnd_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*16-1:0]   out_data,
    output logic [LANES-1:0]      out_inexact
);

    localparam int LZW = $clog2(IN_W + 1);

    // Magnitude of a two's complement word; the most negative value maps to 2^(IN_W-1).
    function automatic logic [IN_W-1:0] abs_mag(input logic [IN_W-1:0] x);
        abs_mag = x[IN_W-1] ? (~x + 1'b1) : x;
    endfunction

    // Leading-zero count; the highest set bit wins because it is visited last.
    function automatic logic [LZW-1:0] count_lz(input logic [IN_W-1:0] v);
        count_lz = LZW'(IN_W);
        for (int b = 0; b < IN_W; b++) begin
            if (v[b]) count_lz = LZW'(IN_W - 1 - b);
        end
    endfunction

    // Returns {inexact, bf16}. The shift by lz+1 drops the hidden bit. The 8 zero
    // bits appended below mag supply zero-fill when the input is narrower than the mantissa.
    function automatic logic [16:0] convert(
        input logic            sign,
        input logic [IN_W-1:0] mag,
        input logic [LZW-1:0]  lz,
        input logic            zero,
        input logic            rne
    );
        logic [IN_W+7:0] ext;
        logic [6:0]      mant;
        logic [7:0]      expo;
        logic            guard;
        logic            sticky;
        int              e;
        ext    = {mag, 8'b0} << (int'(lz) + 1);
        mant   = ext[IN_W+7 -: 7];
        guard  = ext[IN_W];
        sticky = |ext[IN_W-1:0];
        e      = IN_W - 1 - int'(lz) - FRAC_BITS + 127;
        expo   = 8'(e);
        if (rne && guard && (sticky || mant[0])) begin
            if (mant == 7'h7f) begin
                mant = 7'h00;
                expo = expo + 8'd1;
            end else begin
                mant = mant + 7'd1;
            end
        end
        if (zero) convert = 17'h0;
        else      convert = {guard | sticky, sign, expo, mant};
    endfunction

    logic                 s1_valid;
    logic                 s2_valid;
    logic                 s1_en;
    logic                 s2_en;
    logic                 s1_rnd;
    logic [LANES-1:0]     s1_sign;
    logic [LANES-1:0]     s1_zero;
    logic [IN_W-1:0]      s1_mag [LANES];
    logic [LZW-1:0]       s1_lz  [LANES];
    logic [IN_W-1:0]      lane_mag [LANES];
    logic [LZW-1:0]       lane_lz  [LANES];
    logic [LANES*16-1:0]  s2_data_d;
    logic [LANES-1:0]     s2_inx_d;

    // Handshake: a stage loads when it is empty or its successor loads this cycle.
    // in_ready therefore depends only on out_ready and stage occupancy, never on in_valid.
    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_mag[i] = abs_mag(in_data[i*IN_W +: IN_W]);
            lane_lz[i]  = count_lz(lane_mag[i]);
        end
    end

    always_comb begin
        s2_data_d = '0;
        s2_inx_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            {s2_inx_d[i], s2_data_d[i*16 +: 16]} =
                convert(s1_sign[i], s1_mag[i], s1_lz[i], s1_zero[i], s1_rnd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rnd   <= 1'b0;
            s1_sign  <= '0;
            s1_zero  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_mag[i] <= '0;
                s1_lz[i]  <= '0;
            end
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_rnd <= rnd_mode;
                for (int i = 0; i < LANES; i++) begin
                    s1_sign[i] <= in_data[i*IN_W + IN_W - 1];
                    s1_mag[i]  <= lane_mag[i];
                    s1_lz[i]   <= lane_lz[i];
                    s1_zero[i] <= (lane_mag[i] == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_data    <= '0;
            out_inexact <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= s2_data_d;
                out_inexact <= s2_inx_d;
            end
        end
    end

endmodule
